// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
//   Port 0 (CPU load/store) has fixed priority. Port 1 (debug/DMA loader) is
//   granted once port 0 has won MAX_BURST consecutive contested cycles.
//   At most one access per cycle. Memory read data arrives one cycle after the
//   address, and is steered to the port that issued the read.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   req0/addr0/wdata0/we0 -> gnt0      port 0 request and combinational grant
//   rvalid0/rdata0                     port 0 read return
//   req1/addr1/wdata1/we1 -> gnt1      port 1 request and combinational grant
//   rvalid1/rdata1                     port 1 read return
//   maddr/mwdata/mwe, mrdata           memory side
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [31:0]       wdata0,
  input  logic [3:0]        we0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [31:0]       rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata1,
  input  logic [3:0]        we1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [31:0]       rdata1,
  output logic [ADDR_W-1:0] maddr,
  output logic [31:0]       mwdata,
  output logic [3:0]        mwe,
  input  logic [31:0]       mrdata
);

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  logic [3:0]  burst_q, burst_d;
  logic        rvalid0_q, rvalid1_q;
  logic [31:0] rdata0_q, rdata1_q;

  // Grant selection. Gating by reset keeps mwe at 0 while reset is high.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (burst_q == BurstMax) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else if (req0) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory drive; idle defaults to addr0 with no write.
  always_comb begin
    maddr  = addr0;
    mwdata = 32'h0;
    mwe    = 4'h0;
    if (gnt0) begin
      mwdata = wdata0;
      mwe    = we0;
    end else if (gnt1) begin
      maddr  = addr1;
      mwdata = wdata1;
      mwe    = we1;
    end
  end

  // Counts port-0 wins while port 1 waits; any port-1 grant or idle port 1 clears it.
  always_comb begin
    burst_d = 4'h0;
    if (gnt0 && req1) begin
      burst_d = (burst_q == BurstMax) ? burst_q : burst_q + 4'h1;
    end
  end

  // A read outstanding when reset arrives must not surface, so the
  // registered valids are also masked combinationally by reset.
  always_comb begin
    rvalid0 = rvalid0_q & ~reset;
    rvalid1 = rvalid1_q & ~reset;
    rdata0  = rvalid0 ? mrdata : rdata0_q;
    rdata1  = rvalid1 ? mrdata : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q   <= 4'h0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= 32'h0;
      rdata1_q  <= 32'h0;
    end else begin
      burst_q   <= burst_d;
      rvalid0_q <= gnt0 && (we0 == 4'h0);
      rvalid1_q <= gnt1 && (we1 == 4'h0);
      rdata0_q  <= rdata0;
      rdata1_q  <= rdata1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  we0, we1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1, maddr, mwdata, mrdata;
  logic [3:0]  mwe;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .maddr(maddr), .mwdata(mwdata), .mwe(mwe), .mrdata(mrdata)
  );

  // Single-port memory, 1-cycle synchronous read, byte writes.
  logic [31:0] mem [64];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[4] = 32'hDEAD_BEEF;
    mem[8] = 32'h5555_AAAA;
  end
  always @(posedge clk) begin
    mrdata <= mem[maddr[7:2]];
    for (int b = 0; b < 4; b++)
      if (mwe[b]) mem[maddr[7:2]][8*b +: 8] <= mwdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic [31:0] a0,
                       input logic [3:0] w0, input logic [31:0] d0, input logic r1,
                       input logic [31:0] a1, input logic [3:0] w1, input logic [31:0] d1);
    reset = rst; req0 = r0; addr0 = a0; we0 = w0; wdata0 = d0;
    req1 = r1; addr1 = a1; we1 = w1; wdata1 = d1;
  endtask

  typedef struct {
    logic rst; logic r0; logic [31:0] a0; logic [3:0] we0; logic [31:0] wd0;
    logic r1; logic [31:0] a1; logic [3:0] we1; logic [31:0] wd1;
    logic g0; logic g1; logic [3:0] mwe; logic [31:0] maddr;
    logic rv0; logic rv1; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  vec_t vecs [12];

  initial begin
    //          rst r0 a0     we0  wd0           r1 a1     we1  wd1            g0 g1 mwe  maddr  rv0 rv1 rd0           rd1
    vecs[0]  = '{1, 1, 32'h30, 4'hF, 32'hCAFEF00D, 1, 32'h24, 4'h0, 32'h0,        0, 0, 4'h0, 32'h30, 0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 1, 32'h30, 4'hF, 32'hCAFEF00D, 1, 32'h24, 4'h0, 32'h0,        0, 0, 4'h0, 32'h30, 0, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 1, 32'h30, 4'hF, 32'hCAFEF00D, 0, 32'h24, 4'h0, 32'h0,        1, 0, 4'hF, 32'h30, 0, 0, 32'h0,        32'h0};
    vecs[3]  = '{0, 0, 32'h0,  4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        0, 0, 4'h0, 32'h0,  0, 0, 32'h0,        32'h0};
    vecs[4]  = '{0, 1, 32'h10, 4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h10, 0, 0, 32'h0,        32'h0};
    vecs[5]  = '{0, 0, 32'h0,  4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        0, 0, 4'h0, 32'h0,  1, 0, 32'hDEADBEEF, 32'h0};
    vecs[6]  = '{0, 0, 32'h0,  4'h0, 32'h0,        1, 32'h20, 4'h3, 32'h12345678, 0, 1, 4'h3, 32'h20, 0, 0, 32'hDEADBEEF, 32'h0};
    vecs[7]  = '{0, 1, 32'h20, 4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h20, 0, 0, 32'hDEADBEEF, 32'h0};
    vecs[8]  = '{0, 0, 32'h0,  4'h0, 32'h0,        1, 32'h24, 4'h0, 32'h0,        0, 1, 4'h0, 32'h24, 1, 0, 32'h55555678, 32'h0};
    vecs[9]  = '{0, 0, 32'h0,  4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        0, 0, 4'h0, 32'h0,  0, 1, 32'h55555678, 32'hA0000009};
    vecs[10] = '{0, 1, 32'h30, 4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        1, 0, 4'h0, 32'h30, 0, 0, 32'h55555678, 32'hA0000009};
    vecs[11] = '{0, 0, 32'h0,  4'h0, 32'h0,        0, 32'h0,  4'h0, 32'h0,        0, 0, 4'h0, 32'h0,  1, 0, 32'hCAFEF00D, 32'hA0000009};

    // Initial reset so all registers are defined before the table starts.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].a0, vecs[i].we0, vecs[i].wd0,
            vecs[i].r1, vecs[i].a1, vecs[i].we1, vecs[i].wd1);
      @(negedge clk);
      chk($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
      chk($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
      chk($sformatf("v%0d mwe", i), 32'(mwe), 32'(vecs[i].mwe));
      chk($sformatf("v%0d maddr", i), maddr, vecs[i].maddr);
      chk($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].rv0));
      chk($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].rv1));
      chk($sformatf("v%0d rdata0", i), rdata0, vecs[i].rd0);
      chk($sformatf("v%0d rdata1", i), rdata1, vecs[i].rd1);
      @(posedge clk);
      #1;
    end

    // Starvation: both ports reading continuously; expect 4x port 0 then 1x port 1.
    begin
      logic prev_g0, exp_g1;
      prev_g0 = 1'b0;
      drive(0, 1, 32'h10, 4'h0, 32'h0, 1, 32'h24, 4'h0, 32'h0);
      for (int k = 0; k < 16; k++) begin
        if (k == 15) drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        exp_g1 = (k % 5 == 4);
        if (k < 15) begin
          chk($sformatf("starve%0d gnt0", k), 32'(gnt0), 32'(!exp_g1));
          chk($sformatf("starve%0d gnt1", k), 32'(gnt1), 32'(exp_g1));
        end
        if (k > 0) begin
          chk($sformatf("starve%0d rvalid0", k), 32'(rvalid0), 32'(prev_g0));
          chk($sformatf("starve%0d rvalid1", k), 32'(rvalid1), 32'(!prev_g0));
          if (prev_g0) chk($sformatf("starve%0d rdata0", k), rdata0, 32'hDEADBEEF);
          else         chk($sformatf("starve%0d rdata1", k), rdata1, 32'hA0000009);
        end
        prev_g0 = !exp_g1;
        @(posedge clk);
        #1;
      end
    end

    // Reset right after a port-1 read grant: the read must never return.
    drive(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h24, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_seq gnt1", 32'(gnt1), 32'h1);
    @(posedge clk);
    #1;
    drive(1, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_seq rvalid1 in reset", 32'(rvalid1), 32'h0);
    @(posedge clk);
    #1;
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("rst_seq rvalid1 after reset", 32'(rvalid1), 32'h0);
    @(posedge clk);
    #1;
    // Burst counter restarted: 4 port-0 grants before port 1 under contention.
    drive(0, 1, 32'h10, 4'h0, 32'h0, 1, 32'h24, 4'h0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rst_burst%0d gnt0", k), 32'(gnt0), 32'(k != 4));
      chk($sformatf("rst_burst%0d gnt1", k), 32'(gnt1), 32'(k == 4));
      @(posedge clk);
      #1;
    end
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("final rvalid1", 32'(rvalid1), 32'h1);
    chk("final rdata1", rdata1, 32'hA0000009);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the CPU load/store port, port 1 is an auxiliary master (debug/DMA loader).
- Issues at most one memory access per cycle; the memory has a 1-cycle synchronous read.
- Port 0 has fixed priority, bounded by a starvation counter so that port 1 is guaranteed service.
- Sits between the CPU data port and the dmem instance in the top-level.

Parameters:
ADDR_W, 32, address width of both requesters and memory
MAX_BURST, 4, max consecutive port-0 grants while port 1 is pending (legal range 1..15)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
req0  input  1  port 0 access request, held until gnt0
addr0  input  ADDR_W  port 0 byte address
wdata0  input  32  port 0 write data
we0  input  4  port 0 byte write enables; 0 = read
gnt0  output  1  port 0 request accepted this cycle (combinational)
rvalid0  output  1  port 0 read data valid (registered)
rdata0  output  32  port 0 read data
req1  input  1  port 1 access request, held until gnt1
addr1  input  ADDR_W  port 1 byte address
wdata1  input  32  port 1 write data
we1  input  4  port 1 byte write enables; 0 = read
gnt1  output  1  port 1 request accepted this cycle
rvalid1  output  1  port 1 read data valid
rdata1  output  32  port 1 read data
maddr  output  ADDR_W  memory address
mwdata  output  32  memory write data
mwe  output  4  memory byte write enables
mrdata  input  32  memory read data, valid the cycle after the address was presented

Behaviour:
- Reset:
  - gnt0 = gnt1 = 0; rvalid0 = rvalid1 = 0; mwe = 0.
  - Burst counter = 0; outstanding-read owner register cleared.
  - Reset asserted while a read is outstanding: the following cycle shows no rvalid.
  - While reset is high, mwe is forced to 0 regardless of requests.
- Grant selection (combinational, same cycle as req):
  - Neither req: no grant; maddr = addr0, mwdata = 0, mwe = 0.
  - Only req0: gnt0 = 1.
  - Only req1: gnt1 = 1.
  - Both req: gnt1 = 1 if burst counter == MAX_BURST, otherwise gnt0 = 1.
  - gnt0 and gnt1 are never both 1.
- Memory drive:
  - maddr, mwdata and mwe come from the granted port.
  - mwe is nonzero only when a write is granted.
- Burst counter, updated at posedge:
  - gnt0 while req1 is high: counter + 1, saturating at MAX_BURST.
  - gnt1, or req1 low: counter = 0.
- Read return:
  - A granted read (we == 0) registers its owner.
  - Next cycle: the owner's rvalid = 1 and its rdata = mrdata; the other port's rvalid = 0.
  - rdata of a non-owner port is held at its last value.
  - Back-to-back reads from alternating ports each return exactly one cycle after grant, with no bubbles.
- Writes:
  - Complete in the grant cycle.
  - No rvalid is produced.
- Handshake rules:
  - Requester holds req, addr, wdata and we stable until it sees gnt.
  - A requester may assert a new req in the same cycle as a previous rvalid.
  - An ungranted request is not latched; the arbiter is stateless with respect to pending requests.
- Write collision: a write and a read to the same word in consecutive cycles follow memory semantics. Read-after-write returns the new data; no forwarding is done here.
- No X on outputs: all registered outputs have defined reset values, and combinational outputs default to 0 when idle.

Test Plan:
- Reset with req0 = req1 = 1, we0 = 4'hF → mwe = 0, gnt0 = gnt1 = 0 while reset is high. After release, gnt0 = 1 in the first cycle.
- Single port-0 read, addr0 = 0x10, memory holds 0xDEADBEEF → gnt0 in cycle N; rvalid0 = 1 and rdata0 = 0xDEADBEEF in cycle N+1; rvalid1 = 0 throughout.
- Starvation, MAX_BURST = 4: req0 and req1 continuously high, all reads.
  - Grants: gnt0 ×4, then gnt1 ×1, then repeating.
  - rvalid follows each grant by one cycle to the matching port.
- Port-1 write, addr1 = 0x20, wdata1 = 0x12345678, we1 = 4'b0011, no req0 → mwe = 4'b0011 and maddr = 0x20 in the same cycle. A subsequent port-0 read of 0x20 returns the low half updated.
- Alternating single reads: port 0 at cycle N, port 1 at cycle N+1 → rvalid0 at N+1, rvalid1 at N+2, never both high, data matching the respective addresses.
- Reset asserted the cycle after a port-1 read grant → rvalid1 stays 0. The burst counter restarts at 0, checked by 4 port-0 grants before the next port-1 grant under contention.
